// File: rtl/mem_bus_if.sv
// mem_bus_if: memory access stage behind the multicycle control unit.
// It takes one access request from the control unit and runs it as a
// req/ack transaction on the external memory bus.
//   - Address source is picked by memAdrSel: 0 = pc_i (fetch), 1 = alu_res_i (LD/ST).
//   - Address, write enable and write data are registered. They stay stable
//     through any number of wait states.
//   - Read data is captured when the bus acknowledges.
//   - stall_o holds the control FSM until the access completes.
//   - A watchdog moves to a sticky error state if the bus never acknowledges.
//     Setting TIMEOUT = 0 disables the watchdog.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   acc_valid_i, memAdrSel, memWrCtl access request, address select, write select
//   pc_i, alu_res_i, wdata_i        address sources and store data
//   stall_o, done_o, rdata_o, err_o status back to the control unit
//   bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_ack_i, bus_rdata_i  memory bus
module mem_bus_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc_valid_i,
  input  logic              memAdrSel,
  input  logic              memWrCtl,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             accept;
  logic [CNT_W-1:0] wd_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    stall_o = 1'b0;
    done_o  = 1'b0;
    err_o   = 1'b0;
    case (state_q)
      IDLE: begin
        stall_o = acc_valid_i;
        if (acc_valid_i) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        // An ack that arrives on the expiry cycle still completes the access.
        if (bus_ack_i)
          state_d = DONE;
        else if ((TIMEOUT != 0) && (wd_cnt == CNT_LAST))
          state_d = ERR;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err_o = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are registered from the next state, so no input reaches them combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      rdata_o     <= '0;
      wd_cnt      <= '0;
    end else begin
      bus_req_o <= (state_d == BUSY);

      if (accept) begin
        bus_addr_o  <= memAdrSel ? alu_res_i[ADDR_W-1:0] : pc_i[ADDR_W-1:0];
        bus_we_o    <= memWrCtl;
        bus_wdata_o <= wdata_i;
      end else if (state_d != BUSY) begin
        bus_we_o <= 1'b0;
      end

      if ((state_q == BUSY) && bus_ack_i && !bus_we_o)
        rdata_o <= bus_rdata_i;

      if ((state_q == BUSY) && !bus_ack_i)
        wd_cnt <= wd_cnt + 1'b1;
      else if (state_q != BUSY)
        wd_cnt <= '0;
    end
  end

endmodule
